// File: rtl/universal_register.sv
// Parametrised bus register with in-place clear/inc/dec/shift/rotate and a registered carry.
// Optional shadow register with swap, enabled by defining UNIVERSAL_REGISTER_SHADOW_EN.
module universal_register #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load_data,
  input  logic             i_send_data,
  input  logic [2:0]       i_op,
  input  logic             i_serial_in,
  input  logic [WIDTH-1:0] i_bus,
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
  input  logic             i_swap,
`endif
  output logic [WIDTH-1:0] o_bus,
  output logic [WIDTH-1:0] o_unbuffered,
  output logic             o_carry,
  output logic             o_zero
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_CLEAR = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_SHR   = 3'b101;
  localparam logic [2:0] OP_ROL   = 3'b110;
  localparam logic [2:0] OP_ROR   = 3'b111;

  logic [WIDTH-1:0] data_q,  data_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] op_data;
  logic             op_carry;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] dec_diff;

`ifdef UNIVERSAL_REGISTER_SHADOW_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
`endif

  assign inc_sum  = {1'b0, data_q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_diff = data_q - {{(WIDTH-1){1'b0}}, 1'b1};

  // Result of the selected in-place operation, before priority is applied.
  always_comb begin
    op_data  = data_q;
    op_carry = carry_q;
    case (i_op)
      OP_HOLD: begin
        op_data  = data_q;
        op_carry = carry_q;
      end
      OP_CLEAR: begin
        op_data  = '0;
        op_carry = 1'b0;
      end
      OP_INC: begin
        op_data  = inc_sum[WIDTH-1:0];
        op_carry = inc_sum[WIDTH];
      end
      OP_DEC: begin
        // Borrow only when wrapping from zero.
        op_data  = dec_diff;
        op_carry = (data_q == '0);
      end
      OP_SHL: begin
        op_data  = {data_q[WIDTH-2:0], i_serial_in};
        op_carry = data_q[WIDTH-1];
      end
      OP_SHR: begin
        op_data  = {i_serial_in, data_q[WIDTH-1:1]};
        op_carry = data_q[0];
      end
      OP_ROL: begin
        op_data  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        op_carry = data_q[WIDTH-1];
      end
      OP_ROR: begin
        op_data  = {data_q[0], data_q[WIDTH-1:1]};
        op_carry = data_q[0];
      end
      default: begin
        op_data  = data_q;
        op_carry = carry_q;
      end
    endcase
  end

  // Next-state selection: load beats swap beats the in-place operation.
  always_comb begin
    data_d  = data_q;
    carry_d = carry_q;
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
    shadow_d = shadow_q;
    if (i_load_data) begin
      data_d   = i_bus;
      carry_d  = carry_q;
      shadow_d = shadow_q;
    end else if (i_swap) begin
      data_d   = shadow_q;
      carry_d  = carry_q;
      shadow_d = data_q;
    end else begin
      data_d   = op_data;
      carry_d  = op_carry;
      shadow_d = shadow_q;
    end
`else
    if (i_load_data) begin
      data_d  = i_bus;
      carry_d = carry_q;
    end else begin
      data_d  = op_data;
      carry_d = op_carry;
    end
`endif
  end

  // Data and carry registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      data_q  <= RESET_VALUE;
      carry_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end

`ifdef UNIVERSAL_REGISTER_SHADOW_EN
  // Shadow register for swap.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  assign o_bus        = i_send_data ? data_q : {WIDTH{1'bz}};
  assign o_unbuffered = data_q;
  assign o_carry      = carry_q;
  assign o_zero       = (data_q == '0);

endmodule

// File: tb/tb_universal_register.sv
// Directed self-checking bench for universal_register (WIDTH=8, RESET_VALUE=0).
module tb_universal_register;

  logic       i_clock;
  logic       i_reset;
  logic       i_load_data;
  logic       i_send_data;
  logic [2:0] i_op;
  logic       i_serial_in;
  logic [7:0] i_bus;
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
  logic       i_swap;
`endif
  wire  [7:0] o_bus;
  logic [7:0] o_unbuffered;
  logic       o_carry;
  logic       o_zero;

  int n_checks = 0;
  int n_pass   = 0;

  universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_load_data  (i_load_data),
    .i_send_data  (i_send_data),
    .i_op         (i_op),
    .i_serial_in  (i_serial_in),
    .i_bus        (i_bus),
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
    .i_swap       (i_swap),
`endif
    .o_bus        (o_bus),
    .o_unbuffered (o_unbuffered),
    .o_carry      (o_carry),
    .o_zero       (o_zero)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    i_bus       = v;
    i_load_data = 1'b1;
    tick();
    i_load_data = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op);
    i_op = op;
    tick();
    i_op = 3'b000;
  endtask

  initial begin
    i_reset     = 1'b1;
    i_load_data = 1'b0;
    i_send_data = 1'b0;
    i_op        = 3'b000;
    i_serial_in = 1'b0;
    i_bus       = 8'h00;
`ifdef UNIVERSAL_REGISTER_SHADOW_EN
    i_swap      = 1'b0;
`endif
    #12;
    check("rst_data",  {24'h0, o_unbuffered}, 32'h00);
    check("rst_carry", {31'h0, o_carry}, 32'h0);
    check("rst_zero",  {31'h0, o_zero}, 32'h1);
    i_reset = 1'b0;
    tick();

    // Set carry, then load 5A (carry kept) and reset mid-cycle.
    load(8'hFF);
    do_op(3'b010);
    check("inc_wrap_data",  {24'h0, o_unbuffered}, 32'h00);
    check("inc_wrap_carry", {31'h0, o_carry}, 32'h1);
    check("inc_wrap_zero",  {31'h0, o_zero}, 32'h1);
    load(8'h5A);
    check("load_5a",       {24'h0, o_unbuffered}, 32'h5A);
    check("load_keeps_cy", {31'h0, o_carry}, 32'h1);
    i_send_data = 1'b1;
    #1;
    check("bus_send", {24'h0, o_bus}, 32'h5A);
    i_send_data = 1'b0;
    #1;
    check("bus_release", {31'h0, (o_bus === 8'h5A)}, 32'h0);
    #1;
    i_reset     = 1'b1;
    i_send_data = 1'b1;
    #1;
    check("mid_rst_data",  {24'h0, o_unbuffered}, 32'h00);
    check("mid_rst_carry", {31'h0, o_carry}, 32'h0);
    check("mid_rst_bus",   {24'h0, o_bus}, 32'h00);
    tick();
    i_reset     = 1'b0;
    i_send_data = 1'b0;
    tick();

    // Inc/dec wrap.
    load(8'hFF);
    do_op(3'b010);
    check("inc_ff_data",  {24'h0, o_unbuffered}, 32'h00);
    check("inc_ff_carry", {31'h0, o_carry}, 32'h1);
    do_op(3'b011);
    check("dec_0_data",  {24'h0, o_unbuffered}, 32'hFF);
    check("dec_0_carry", {31'h0, o_carry}, 32'h1);
    do_op(3'b011);
    check("dec_ff_data",  {24'h0, o_unbuffered}, 32'hFE);
    check("dec_ff_carry", {31'h0, o_carry}, 32'h0);

    // Load beats op.
    i_bus       = 8'hC3;
    i_load_data = 1'b1;
    i_op        = 3'b010;
    tick();
    i_load_data = 1'b0;
    check("load_prio_data",  {24'h0, o_unbuffered}, 32'hC3);
    check("load_prio_carry", {31'h0, o_carry}, 32'h0);
    do_op(3'b010);
    check("inc_c3", {24'h0, o_unbuffered}, 32'hC4);

    // Shifts and clear.
    load(8'h81);
    i_serial_in = 1'b0;
    do_op(3'b100);
    check("shl_data",  {24'h0, o_unbuffered}, 32'h02);
    check("shl_carry", {31'h0, o_carry}, 32'h1);
    do_op(3'b001);
    check("clr_data",  {24'h0, o_unbuffered}, 32'h00);
    check("clr_carry", {31'h0, o_carry}, 32'h0);
    check("clr_zero",  {31'h0, o_zero}, 32'h1);
    load(8'h81);
    i_serial_in = 1'b1;
    do_op(3'b101);
    i_serial_in = 1'b0;
    check("shr_data",  {24'h0, o_unbuffered}, 32'hC0);
    check("shr_carry", {31'h0, o_carry}, 32'h1);

    // Rotates.
    load(8'h81);
    do_op(3'b110);
    check("rol_data",  {24'h0, o_unbuffered}, 32'h03);
    check("rol_carry", {31'h0, o_carry}, 32'h1);
    load(8'h02);
    do_op(3'b111);
    check("ror_data",  {24'h0, o_unbuffered}, 32'h01);
    check("ror_carry", {31'h0, o_carry}, 32'h0);
    load(8'h81);
    for (int i = 0; i < 8; i++) begin
      do_op(3'b110);
    end
    check("rol8_data",  {24'h0, o_unbuffered}, 32'h81);
    check("rol8_carry", {31'h0, o_carry}, 32'h1);
    do_op(3'b000);
    check("hold_data",  {24'h0, o_unbuffered}, 32'h81);
    check("hold_carry", {31'h0, o_carry}, 32'h1);

    // Send and load the same value together.
    i_send_data = 1'b1;
    i_bus       = 8'h81;
    i_load_data = 1'b1;
    tick();
    i_load_data = 1'b0;
    check("send_load", {24'h0, o_bus}, 32'h81);
    i_send_data = 1'b0;

`ifdef UNIVERSAL_REGISTER_SHADOW_EN
    load(8'hAA);
    i_swap = 1'b1;
    i_op   = 3'b010;
    tick();
    i_op   = 3'b000;
    check("swap1_data",  {24'h0, o_unbuffered}, 32'h00);
    check("swap1_carry", {31'h0, o_carry}, 32'h1);
    tick();
    i_swap = 1'b0;
    check("swap2_data", {24'h0, o_unbuffered}, 32'hAA);
    i_swap      = 1'b1;
    i_bus       = 8'h11;
    i_load_data = 1'b1;
    tick();
    i_load_data = 1'b0;
    check("load_over_swap", {24'h0, o_unbuffered}, 32'h11);
    tick();
    i_swap = 1'b0;
    check("shadow_kept", {24'h0, o_unbuffered}, 32'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
